// File: rtl/axi_inf_write_slave_core.sv
// rtl/axi_inf_write_slave_core.sv - AXI4 single-outstanding write responder feeding a memory write port
//
// Ports:
//   axi_aclk / axi_resetn       clock, asynchronous active-low reset
//   axi_aw*                     write address channel (INCR bursts, awsize = log2(DSIZE/8))
//   axi_w*                      write data channel
//   axi_b*                      write response channel (bid echoes awid)
//   mem_wr_*                    backpressured memory write port (mem_wr_ready)
//   wr_done / wr_err            one-cycle pulses after the B handshake
//   busy                        high while a transaction is in flight
module axi_inf_write_slave_core #(
  parameter int IDSIZE = 3,
  parameter int LSIZE  = 8,
  parameter int ASIZE  = 32,
  parameter int DSIZE  = 256
) (
  input  logic                 axi_aclk,
  input  logic                 axi_resetn,
  input  logic [IDSIZE-1:0]    axi_awid,
  input  logic [ASIZE-1:0]     axi_awaddr,
  input  logic [LSIZE-1:0]     axi_awlen,
  input  logic [2:0]           axi_awsize,
  input  logic [1:0]           axi_awburst,
  input  logic                 axi_awvalid,
  output logic                 axi_awready,
  input  logic [DSIZE-1:0]     axi_wdata,
  input  logic [DSIZE/8-1:0]   axi_wstrb,
  input  logic                 axi_wlast,
  input  logic                 axi_wvalid,
  output logic                 axi_wready,
  output logic [IDSIZE-1:0]    axi_bid,
  output logic [1:0]           axi_bresp,
  output logic                 axi_bvalid,
  input  logic                 axi_bready,
  output logic                 mem_wr_en,
  output logic [ASIZE-1:0]     mem_wr_addr,
  output logic [DSIZE-1:0]     mem_wr_data,
  output logic [DSIZE/8-1:0]   mem_wr_strb,
  input  logic                 mem_wr_ready,
  output logic                 wr_done,
  output logic                 wr_err,
  output logic                 busy
);

  localparam int BYTES = DSIZE / 8;
  localparam int SZ    = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t              state_q, state_d;
  logic                awready_q, bvalid_q, busy_q, wr_done_q, wr_err_q;
  logic [IDSIZE-1:0]   id_q, id_d;
  logic [ASIZE-1:0]    addr_q, addr_d;
  logic [LSIZE-1:0]    len_q, len_d;
  logic [LSIZE:0]      cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                aw_hs, w_hs, b_hs, overrun;

  assign aw_hs   = (state_q == IDLE) && axi_awvalid && awready_q;
  // Once the burst is known bad, beats are drained regardless of the memory.
  assign axi_wready = (state_q == DATA) && (err_q || mem_wr_ready);
  assign w_hs    = axi_wvalid && axi_wready;
  assign b_hs    = (state_q == RESP) && bvalid_q && axi_bready;
  assign overrun = cnt_q > {1'b0, len_q};

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          state_d = DATA;
          id_d    = axi_awid;
          addr_d  = axi_awaddr;
          len_d   = axi_awlen;
          cnt_d   = '0;
          err_d   = (axi_awburst != 2'b01) || (axi_awsize != 3'(SZ));
        end
      end
      DATA: begin
        if (w_hs) begin
          // Saturate so a runaway burst can never wrap back into the legal range.
          if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
          if (overrun || (axi_wlast && (cnt_q != {1'b0, len_q}))) err_d = 1'b1;
          if (axi_wlast) state_d = RESP;
        end
      end
      RESP: begin
        if (b_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    bresp_d = (state_d == RESP) ? (err_d ? 2'b10 : 2'b00) : 2'b00;
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_done_q <= 1'b0;
      wr_err_q  <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      awready_q <= (state_d == IDLE);
      bvalid_q  <= (state_d == RESP);
      busy_q    <= (state_d != IDLE);
      wr_done_q <= b_hs;
      wr_err_q  <= b_hs && (bresp_q == 2'b10);
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      bresp_q   <= bresp_d;
    end
  end

  assign axi_awready = awready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bid     = id_q;
  assign axi_bresp   = bresp_q;
  assign busy        = busy_q;
  assign wr_done     = wr_done_q;
  assign wr_err      = wr_err_q;

  // Overrun beats are accepted but never reach memory.
  assign mem_wr_en   = w_hs && !err_q && !overrun;
  assign mem_wr_addr = addr_q + (ASIZE'(cnt_q) << SZ);
  assign mem_wr_data = axi_wdata;
  assign mem_wr_strb = axi_wstrb;

endmodule

// File: tb/tb_axi_inf_write_slave_core.sv
// tb/tb_axi_inf_write_slave_core.sv - directed bench for axi_inf_write_slave_core
module tb_axi_inf_write_slave_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   awid = '0;
  logic [31:0]  awaddr = '0;
  logic [7:0]   awlen = '0;
  logic [2:0]   awsize = '0;
  logic [1:0]   awburst = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [255:0] wdata = '0;
  logic [31:0]  wstrb = '0;
  logic         wlast = 1'b0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [2:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic         mem_wr_en;
  logic [31:0]  mem_wr_addr;
  logic [255:0] mem_wr_data;
  logic [31:0]  mem_wr_strb;
  logic         mem_wr_ready = 1'b1;
  logic         wr_done, wr_err, busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]  addr_log[$];
  logic [255:0] data_log[$];
  int           en_cnt = 0;
  int           b_hs_cnt = 0;

  always #5 clk = ~clk;

  axi_inf_write_slave_core dut (
    .axi_aclk(clk), .axi_resetn(rst_n),
    .axi_awid(awid), .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(awsize),
    .axi_awburst(awburst), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast), .axi_wvalid(wvalid),
    .axi_wready(wready), .axi_bid(bid), .axi_bresp(bresp), .axi_bvalid(bvalid),
    .axi_bready(bready), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb), .mem_wr_ready(mem_wr_ready),
    .wr_done(wr_done), .wr_err(wr_err), .busy(busy)
  );

  // Inputs change 1 ns after posedge, so the negedge sees what the next posedge will commit.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      en_cnt++;
      if (mem_wr_ready) begin
        addr_log.push_back(mem_wr_addr);
        data_log.push_back(mem_wr_data);
      end
    end
    if (bvalid && bready) b_hs_cnt++;
  end

  task automatic clear_logs();
    addr_log.delete();
    data_log.delete();
    en_cnt = 0;
  endtask

  task automatic send_aw(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic ok;
    ok = 1'b0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL aw_timeout: awready=%0b required 1", awready);
    end
  endtask

  // Sends n beats; wlast is raised on beat number last_pos (1-based), 0 = never.
  task automatic send_beats(input int n, input int last_pos);
    logic ok;
    for (int b = 0; b < n; b++) begin
      ok = 1'b0;
      wdata = {8{32'(b + 1)}}; wstrb = '1; wvalid = 1'b1; wlast = (b + 1 == last_pos);
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (wready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      if (!ok) begin
        n_tests++; n_fail++;
        $display("FAIL w_timeout: beat %0d wready=%0b required 1", b, wready);
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic finish_b(output logic [2:0] id_o, output logic [1:0] resp_o);
    logic ok;
    ok = 1'b0;
    bready = 1'b1;
    id_o = 'x; resp_o = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1'b1; id_o = bid; resp_o = bresp; break; end
    end
    @(posedge clk); #1;
    bready = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL b_timeout: bvalid=%0b required 1", bvalid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if ({awready, wready, bvalid, busy, mem_wr_en, wr_done, wr_err} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outs: got %b required 0000000",
                          {awready, wready, bvalid, busy, mem_wr_en, wr_done, wr_err});
    end
    n_tests++; if ({bid, bresp} !== 5'b0) begin
      n_fail++; $display("FAIL reset_bid_bresp: got %b required 00000", {bid, bresp});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (awready !== 1'b0) begin
      n_fail++; $display("FAIL reset_awready_early: got %b required 0", awready);
    end
    @(posedge clk); #1;
    n_tests++; if (awready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_awready_rise: awready=%b busy=%b required 1 0", awready, busy);
    end
  endtask

  task automatic test_single();
    logic [2:0] id; logic [1:0] rs;
    clear_logs();
    send_aw(3'd5, 32'h100, 8'd0, 3'b101, 2'b01);
    n_tests++; if (busy !== 1'b1 || awready !== 1'b0) begin
      n_fail++; $display("FAIL single_busy: busy=%b awready=%b required 1 0", busy, awready);
    end
    send_beats(1, 1);
    n_tests++; if (bvalid !== 1'b1) begin
      n_fail++; $display("FAIL single_bvalid_latency: got %b required 1", bvalid);
    end
    finish_b(id, rs);
    n_tests++; if (id !== 3'd5 || rs !== 2'b00) begin
      n_fail++; $display("FAIL single_b: bid=%0d bresp=%b required 5 00", id, rs);
    end
    n_tests++; if (wr_done !== 1'b1 || wr_err !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
      n_fail++; $display("FAIL single_done: done=%b err=%b awready=%b bvalid=%b required 1 0 1 0",
                          wr_done, wr_err, awready, bvalid);
    end
    @(posedge clk); #1;
    n_tests++; if (wr_done !== 1'b0) begin
      n_fail++; $display("FAIL single_done_width: got %b required 0", wr_done);
    end
    n_tests++; if (addr_log.size() != 1 || en_cnt != 1) begin
      n_fail++; $display("FAIL single_nwrites: got %0d required 1", addr_log.size());
    end else if (addr_log[0] !== 32'h100 || data_log[0] !== {8{32'd1}}) begin
      n_tests++; n_fail++; $display("FAIL single_addr: got %h required 00000100", addr_log[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] id; logic [1:0] rs;
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'h1000; exp_addr[1] = 32'h1020; exp_addr[2] = 32'h1040; exp_addr[3] = 32'h1060;
    clear_logs();
    send_aw(3'd2, 32'h1000, 8'd3, 3'b101, 2'b01);
    send_beats(1, 0);
    mem_wr_ready = 1'b0; wvalid = 1'b1; wdata = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (wready !== 1'b0 || mem_wr_en !== 1'b0) begin
        n_fail++; $display("FAIL bp_stall: cycle %0d wready=%b en=%b required 0 0", i, wready, mem_wr_en);
      end
      @(posedge clk); #1;
    end
    mem_wr_ready = 1'b1;
    #1;
    n_tests++; if (wready !== 1'b1) begin
      n_fail++; $display("FAIL bp_resume: wready=%b required 1", wready);
    end
    send_beats(3, 3);
    finish_b(id, rs);
    n_tests++; if (id !== 3'd2 || rs !== 2'b00) begin
      n_fail++; $display("FAIL bp_b: bid=%0d bresp=%b required 2 00", id, rs);
    end
    n_tests++; if (addr_log.size() != 4) begin
      n_fail++; $display("FAIL bp_nwrites: got %0d required 4", addr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++; if (addr_log[i] !== exp_addr[i]) begin
          n_fail++; $display("FAIL bp_addr%0d: got %h required %h", i, addr_log[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_bad_size();
    logic [2:0] id; logic [1:0] rs;
    clear_logs();
    mem_wr_ready = 1'b0;
    send_aw(3'd1, 32'h200, 8'd1, 3'b010, 2'b01);
    send_beats(2, 2);
    finish_b(id, rs);
    mem_wr_ready = 1'b1;
    n_tests++; if (en_cnt != 0) begin
      n_fail++; $display("FAIL badsize_writes: got %0d required 0", en_cnt);
    end
    n_tests++; if (rs !== 2'b10 || id !== 3'd1) begin
      n_fail++; $display("FAIL badsize_b: bid=%0d bresp=%b required 1 10", id, rs);
    end
    n_tests++; if (wr_err !== 1'b1 || wr_done !== 1'b1) begin
      n_fail++; $display("FAIL badsize_pulse: err=%b done=%b required 1 1", wr_err, wr_done);
    end
  endtask

  task automatic test_len_mismatch();
    logic [2:0] id; logic [1:0] rs;
    clear_logs();
    send_aw(3'd3, 32'h2000, 8'd3, 3'b101, 2'b01);
    send_beats(2, 2);
    finish_b(id, rs);
    n_tests++; if (addr_log.size() != 2 || rs !== 2'b10) begin
      n_fail++; $display("FAIL short_burst: writes=%0d bresp=%b required 2 10", addr_log.size(), rs);
    end
    @(posedge clk); #1;
    clear_logs();
    send_aw(3'd4, 32'h2000, 8'd3, 3'b101, 2'b01);
    send_beats(5, 5);
    finish_b(id, rs);
    n_tests++; if (addr_log.size() != 4 || rs !== 2'b10) begin
      n_fail++; $display("FAIL long_burst: writes=%0d bresp=%b required 4 10", addr_log.size(), rs);
    end
    n_tests++; if (addr_log.size() == 4 && addr_log[3] !== 32'h2060) begin
      n_fail++; $display("FAIL long_last_addr: got %h required 00002060", addr_log[3]);
    end
  endtask

  task automatic test_bready_hold();
    logic [2:0] id; logic [1:0] rs;
    @(posedge clk); #1;
    send_aw(3'd6, 32'h500, 8'd0, 3'b101, 2'b01);
    send_beats(1, 1);
    awid = 3'd1; awaddr = 32'h600; awlen = 8'd0; awsize = 3'b101; awburst = 2'b01; awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++; if (bvalid !== 1'b1 || bid !== 3'd6 || bresp !== 2'b00 || awready !== 1'b0) begin
        n_fail++; $display("FAIL hold_b: cycle %0d bvalid=%b bid=%0d bresp=%b awready=%b required 1 6 00 0",
                            i, bvalid, bid, bresp, awready);
      end
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    n_tests++; if (awready !== 1'b1 || busy !== 1'b0 || bvalid !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: awready=%b busy=%b bvalid=%b required 1 0 0", awready, busy, bvalid);
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    n_tests++; if (awready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL hold_second_aw: awready=%b busy=%b required 0 1", awready, busy);
    end
    send_beats(1, 1);
    finish_b(id, rs);
    n_tests++; if (id !== 3'd1 || rs !== 2'b00) begin
      n_fail++; $display("FAIL hold_second_b: bid=%0d bresp=%b required 1 00", id, rs);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] id; logic [1:0] rs;
    int b_before;
    @(posedge clk); #1;
    send_aw(3'd7, 32'h3000, 8'd7, 3'b101, 2'b01);
    send_beats(1, 0);
    wvalid = 1'b1; bready = 1'b1;
    b_before = b_hs_cnt;
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({awready, wready, bvalid, busy, mem_wr_en, wr_done, wr_err} !== 7'b0) begin
      n_fail++; $display("FAIL midrst_outs: got %b required 0000000",
                          {awready, wready, bvalid, busy, mem_wr_en, wr_done, wr_err});
    end
    repeat (3) @(posedge clk);
    #1;
    wvalid = 1'b0; bready = 1'b0;
    rst_n = 1'b1;
    n_tests++; if (b_hs_cnt != b_before) begin
      n_fail++; $display("FAIL midrst_no_b: got %0d handshakes required 0", b_hs_cnt - b_before);
    end
    @(posedge clk); #1;
    n_tests++; if (awready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_awready: got %b required 1", awready);
    end
    clear_logs();
    send_aw(3'd3, 32'h40, 8'd0, 3'b101, 2'b01);
    send_beats(1, 1);
    finish_b(id, rs);
    n_tests++; if (id !== 3'd3 || rs !== 2'b00 || addr_log.size() != 1) begin
      n_fail++; $display("FAIL midrst_after: bid=%0d bresp=%b writes=%0d required 3 00 1",
                          id, rs, addr_log.size());
    end else begin
      n_tests++; if (addr_log[0] !== 32'h40) begin
        n_fail++; $display("FAIL midrst_addr: got %h required 00000040", addr_log[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_bad_size();
    test_len_mismatch();
    test_bready_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
